// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer slice.
// Field slice positions match the 16-bit instruction format.
package fetch_sequencer_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      IMM   = 1'b1
   } state_e;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 10;
   localparam int SRC_HI = 9;
   localparam int SRC_LO = 7;
   localparam int DST_HI = 6;
   localparam int DST_LO = 4;
   localparam int SH_HI  = 3;
   localparam int SH_LO  = 0;

   localparam logic [1:0] TWO_WORD_CLASS = 2'b01;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0010;

   typedef struct packed {
      logic [5:0] opcode;
      logic [2:0] src;
      logic [2:0] dst;
      logic [3:0] shamt;
   } fields_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory, control from later stages,
// and the decode bundle.
interface fetch_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_data;
   logic              stall;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              int_req;
   logic              int_ack;
   logic [ADDR_W-1:0] epc;
   logic              if_valid;
   logic [5:0]        if_opcode;
   logic [2:0]        if_src;
   logic [2:0]        if_dst;
   logic [3:0]        if_shamt;
   logic [15:0]       if_imm;
   logic [ADDR_W-1:0] if_pc;

   modport master (
      output imem_addr, int_ack, epc,
      output if_valid, if_opcode, if_src,
      output if_dst, if_shamt, if_imm, if_pc,
      input  imem_data, stall, redirect_valid,
      input  redirect_pc, int_req
   );

   modport slave (
      input  imem_addr, int_ack, epc,
      input  if_valid, if_opcode, if_src,
      input  if_dst, if_shamt, if_imm, if_pc,
      output imem_data, stall, redirect_valid,
      output redirect_pc, int_req
   );
endinterface

// File: rtl/fetch_sequencer_instr_splitter.sv
// Combinational split of a 16-bit word into decode fields
// plus the two-word class flag.
module instr_splitter
   import fetch_sequencer_pkg::*;
(
   input  logic [15:0] word_i,
   output fields_t     fields_o,
   output logic        two_word_o
);
   assign fields_o.opcode = word_i[OPC_HI:OPC_LO];
   assign fields_o.src    = word_i[SRC_HI:SRC_LO];
   assign fields_o.dst    = word_i[DST_HI:DST_LO];
   assign fields_o.shamt  = word_i[SH_HI:SH_LO];
   assign two_word_o =
      (word_i[OPC_HI:OPC_HI-1] == TWO_WORD_CLASS);
endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and fetch sequencer: single/two-word
// assembly, stall, redirect and interrupt entry.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC =
      ADDR_W'(DEF_RESET_PC),
   parameter logic [ADDR_W-1:0] INT_VECTOR =
      ADDR_W'(DEF_INT_VECTOR)
) (
   input logic clk,
   input logic rst_n,
   fetch_sequencer_if.master bus
);
   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc_d;
   logic [15:0]       hold_word_q;
   logic [ADDR_W-1:0] hold_pc_q;
   logic              valid_q;
   fields_t           fields_q;
   logic [15:0]       imm_q;
   logic [ADDR_W-1:0] if_pc_q;
   logic [ADDR_W-1:0] epc_q;
   logic              ack_q;

   fields_t mem_f;
   logic    mem_two;
   fields_t hold_f;
   logic    hold_two;

   instr_splitter u_split_mem (
      .word_i     (bus.imem_data),
      .fields_o   (mem_f),
      .two_word_o (mem_two)
   );

   instr_splitter u_split_hold (
      .word_i     (hold_word_q),
      .fields_o   (hold_f),
      .two_word_o (hold_two)
   );

   // modulo 2^ADDR_W: all-ones wraps to zero
   assign pc_inc_d = pc_q + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         hold_word_q <= '0;
         hold_pc_q   <= '0;
         valid_q     <= 1'b0;
         fields_q    <= '0;
         imm_q       <= '0;
         if_pc_q     <= '0;
         epc_q       <= '0;
         ack_q       <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (bus.redirect_valid) begin
            pc_q        <= bus.redirect_pc;
            state_q     <= FETCH;
            valid_q     <= 1'b0;
            hold_word_q <= '0;
            hold_pc_q   <= '0;
         end else if (bus.stall) begin
            pc_q <= pc_q;
         end else begin
            unique case (state_q)
               FETCH: begin
                  if (bus.int_req) begin
                     pc_q    <= INT_VECTOR;
                     epc_q   <= pc_q;
                     ack_q   <= 1'b1;
                     valid_q <= 1'b0;
                  end else if (mem_two) begin
                     hold_word_q <= bus.imem_data;
                     hold_pc_q   <= pc_q;
                     valid_q     <= 1'b0;
                     pc_q        <= pc_inc_d;
                     state_q     <= IMM;
                  end else begin
                     fields_q <= mem_f;
                     imm_q    <= '0;
                     if_pc_q  <= pc_q;
                     valid_q  <= 1'b1;
                     pc_q     <= pc_inc_d;
                  end
               end
               IMM: begin
                  fields_q <= hold_f;
                  imm_q    <= bus.imem_data;
                  if_pc_q  <= hold_pc_q;
                  valid_q  <= hold_two;
                  pc_q     <= pc_inc_d;
                  state_q  <= FETCH;
               end
               default: state_q <= FETCH;
            endcase
         end
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.int_ack   = ack_q;
   assign bus.epc       = epc_q;
   assign bus.if_valid  = valid_q;
   assign bus.if_opcode = fields_q.opcode;
   assign bus.if_src    = fields_q.src;
   assign bus.if_dst    = fields_q.dst;
   assign bus.if_shamt  = fields_q.shamt;
   assign bus.if_imm    = imm_q;
   assign bus.if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table plus
// hand-written wrap and mid-IMM reset sequences.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic rst_na;
   logic rst_nb;

   always #5 clk = ~clk;

   fetch_sequencer_if #(.ADDR_W(32)) ba ();
   fetch_sequencer_if #(.ADDR_W(32)) bb ();

   fetch_sequencer #(
      .ADDR_W     (32),
      .RESET_PC   (32'h0),
      .INT_VECTOR (32'h10)
   ) u_dut_a (
      .clk   (clk),
      .rst_n (rst_na),
      .bus   (ba.master)
   );

   fetch_sequencer #(
      .ADDR_W     (32),
      .RESET_PC   (32'hFFFF_FFFF),
      .INT_VECTOR (32'h10)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_nb),
      .bus   (bb.master)
   );

   logic [15:0] mem_a [0:127];
   assign ba.imem_data = mem_a[ba.imem_addr[6:0]];

   function automatic logic [15:0] mem_b(
      input logic [31:0] a
   );
      case (a)
         32'hFFFF_FFFF: return 16'h4470;
         32'h0000_0000: return 16'hCAFE;
         32'h0000_0001: return 16'h0C10;
         default:       return 16'h0000;
      endcase
   endfunction
   assign bb.imem_data = mem_b(bb.imem_addr);

   int checks = 0;
   int errors = 0;

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        irq;
      logic        v;
      logic [5:0]  op;
      logic [2:0]  src;
      logic [2:0]  dst;
      logic [3:0]  sh;
      logic [15:0] imm;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] epc;
      logic        ack;
   } vec_t;

   function automatic vec_t mk(
      input logic st, input logic rd,
      input logic [31:0] rp, input logic iq,
      input logic v, input logic [5:0] op,
      input logic [2:0] s, input logic [2:0] d,
      input logic [3:0] sh, input logic [15:0] im,
      input logic [31:0] pc, input logic [31:0] ad,
      input logic [31:0] ep, input logic ak
   );
      vec_t r;
      r.stall = st; r.redir = rd; r.rpc = rp;
      r.irq = iq; r.v = v; r.op = op;
      r.src = s; r.dst = d; r.sh = sh;
      r.imm = im; r.pc = pc; r.addr = ad;
      r.epc = ep; r.ack = ak;
      return r;
   endfunction

   task automatic chk_a(input string t, input vec_t e);
      chk({t, " valid"}, 32'(ba.if_valid), 32'(e.v));
      chk({t, " opcode"}, 32'(ba.if_opcode), 32'(e.op));
      chk({t, " src"}, 32'(ba.if_src), 32'(e.src));
      chk({t, " dst"}, 32'(ba.if_dst), 32'(e.dst));
      chk({t, " shamt"}, 32'(ba.if_shamt), 32'(e.sh));
      chk({t, " imm"}, 32'(ba.if_imm), 32'(e.imm));
      chk({t, " if_pc"}, ba.if_pc, e.pc);
      chk({t, " imem_addr"}, ba.imem_addr, e.addr);
      chk({t, " epc"}, ba.epc, e.epc);
      chk({t, " int_ack"}, 32'(ba.int_ack), 32'(e.ack));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vt [22];

   initial begin
      for (int i = 0; i < 128; i++) mem_a[i] = 16'h0;
      mem_a[0]    = 16'h0C10;
      mem_a[1]    = 16'h1010;
      mem_a[2]    = 16'h1410;
      mem_a[3]    = 16'h4470;
      mem_a[4]    = 16'hBEEF;
      mem_a[5]    = 16'h2010;
      mem_a[7'h10] = 16'h3C00;
      mem_a[7'h11] = 16'h5000;
      mem_a[7'h12] = 16'h1234;
      mem_a[7'h13] = 16'h4470;
      mem_a[7'h40] = 16'h38A5;

      // st rd rpc irq | v op src dst sh imm pc addr epc ack
      vt[0]  = mk(0,0,0,0, 1,6'h03,0,1,0,16'h0,0,1,0,0);
      vt[1]  = mk(0,0,0,0, 1,6'h04,0,1,0,16'h0,1,2,0,0);
      vt[2]  = mk(0,0,0,0, 1,6'h05,0,1,0,16'h0,2,3,0,0);
      vt[3]  = mk(0,0,0,0, 0,6'h05,0,1,0,16'h0,2,4,0,0);
      vt[4]  = mk(0,0,0,0,
                  1,6'h11,0,7,0,16'hBEEF,3,5,0,0);
      vt[5]  = mk(0,0,0,1,
                  0,6'h11,0,7,0,16'hBEEF,3,'h10,5,1);
      vt[6]  = mk(0,0,0,0,
                  1,6'h0F,0,0,0,16'h0,'h10,'h11,5,0);
      vt[7]  = mk(0,0,0,0,
                  0,6'h0F,0,0,0,16'h0,'h10,'h12,5,0);
      vt[8]  = mk(0,0,0,1,
                  1,6'h14,0,0,0,16'h1234,'h11,'h13,5,0);
      vt[9]  = mk(0,0,0,1,
                  0,6'h14,0,0,0,16'h1234,'h11,'h10,'h13,1);
      vt[10] = mk(0,0,0,0,
                  1,6'h0F,0,0,0,16'h0,'h10,'h11,'h13,0);
      vt[11] = mk(1,0,0,0,
                  1,6'h0F,0,0,0,16'h0,'h10,'h11,'h13,0);
      vt[12] = vt[11];
      vt[13] = vt[11];
      vt[14] = mk(0,0,0,0,
                  0,6'h0F,0,0,0,16'h0,'h10,'h12,'h13,0);
      vt[15] = mk(1,0,0,0,
                  0,6'h0F,0,0,0,16'h0,'h10,'h12,'h13,0);
      vt[16] = mk(0,0,0,0,
                  1,6'h14,0,0,0,16'h1234,'h11,'h13,'h13,0);
      vt[17] = mk(0,0,0,0,
                  0,6'h14,0,0,0,16'h1234,'h11,'h14,'h13,0);
      vt[18] = mk(1,1,'h40,0,
                  0,6'h14,0,0,0,16'h1234,'h11,'h40,'h13,0);
      vt[19] = mk(0,0,0,0,
                  1,6'h0E,1,2,5,16'h0,'h40,'h41,'h13,0);
      vt[20] = mk(0,1,'h2,1,
                  0,6'h0E,1,2,5,16'h0,'h40,'h2,'h13,0);
      vt[21] = mk(0,0,0,0,
                  1,6'h05,0,1,0,16'h0,'h2,'h3,'h13,0);

      rst_na = 1'b0;
      rst_nb = 1'b0;
      ba.stall = 0; ba.redirect_valid = 0;
      ba.redirect_pc = 0; ba.int_req = 0;
      bb.stall = 0; bb.redirect_valid = 0;
      bb.redirect_pc = 0; bb.int_req = 0;

      step();
      step();
      chk_a("reset",
            mk(0,0,0,0, 0,0,0,0,0,16'h0,0,0,0,0));
      @(negedge clk);
      rst_na = 1'b1;

      for (int i = 0; i < 22; i++) begin
         ba.stall          = vt[i].stall;
         ba.redirect_valid = vt[i].redir;
         ba.redirect_pc    = vt[i].rpc;
         ba.int_req        = vt[i].irq;
         step();
         chk_a($sformatf("vec%0d", i), vt[i]);
      end
      ba.stall = 0; ba.redirect_valid = 0;
      ba.int_req = 0;

      // wrap: two-word instruction at the top of memory
      chk("wrap rst addr", bb.imem_addr, 32'hFFFF_FFFF);
      @(negedge clk);
      rst_nb = 1'b1;
      step();
      chk("wrap bubble", 32'(bb.if_valid), 0);
      chk("wrap imm addr", bb.imem_addr, 32'h0);
      step();
      chk("wrap valid", 32'(bb.if_valid), 1);
      chk("wrap opcode", 32'(bb.if_opcode), 32'h11);
      chk("wrap dst", 32'(bb.if_dst), 7);
      chk("wrap imm", 32'(bb.if_imm), 32'hCAFE);
      chk("wrap if_pc", bb.if_pc, 32'hFFFF_FFFF);
      chk("wrap next pc", bb.imem_addr, 32'h1);
      step();
      chk("post wrap op", 32'(bb.if_opcode), 32'h03);
      chk("post wrap pc", bb.if_pc, 32'h1);

      // enter IMM again, then reset mid-cycle
      bb.redirect_valid = 1'b1;
      bb.redirect_pc    = 32'hFFFF_FFFF;
      step();
      bb.redirect_valid = 1'b0;
      step();
      chk("pre-rst imm addr", bb.imem_addr, 32'h0);
      #2;
      rst_nb = 1'b0;
      #1;
      chk("mid rst valid", 32'(bb.if_valid), 0);
      chk("mid rst fields",
          {16'h0, bb.if_opcode, bb.if_src,
           bb.if_dst, bb.if_shamt}, 32'h0);
      chk("mid rst imm", 32'(bb.if_imm), 0);
      chk("mid rst if_pc", bb.if_pc, 0);
      chk("mid rst epc", bb.epc, 0);
      chk("mid rst ack", 32'(bb.int_ack), 0);
      chk("mid rst addr", bb.imem_addr, 32'hFFFF_FFFF);
      @(negedge clk);
      rst_nb = 1'b1;
      step();
      chk("rst fetch state", 32'(bb.if_valid), 0);
      chk("rst fetch addr", bb.imem_addr, 32'h0);
      step();
      chk("rst refetch imm", 32'(bb.if_imm), 32'hCAFE);
      chk("rst refetch valid", 32'(bb.if_valid), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
